// File: rtl/charge_hold_driver.sv
// Two-lane bus driver with trireg-style charge retention after release.
// Define CHARGE_DECAY_EN to enable the per-lane decay timer; otherwise HOLD persists.

module charge_hold_lane #(
  parameter int WIDTH        = 16,
  parameter int DRIVE_CYCLES = 2,
  parameter int DECAY_CYCLES = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [WIDTH-1:0] in_data,
  output logic             drive,
  output logic             known,
  output logic [WIDTH-1:0] data,
  output logic             pulse
);
  localparam int DRW = $clog2(DRIVE_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [DRW-1:0]   drv_cnt_q, drv_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             pulse_q, pulse_d;

`ifdef CHARGE_DECAY_EN
  localparam int DKW = $clog2(DECAY_CYCLES) + 1;
  logic [DKW-1:0]   dk_cnt_q, dk_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    drv_cnt_d = drv_cnt_q;
    data_d    = data_q;
    pulse_d   = 1'b0;
`ifdef CHARGE_DECAY_EN
    dk_cnt_d  = dk_cnt_q;
`endif
    case (state_q)
      IDLE: ;
      DRIVE: begin
        if (drv_cnt_q == '0) begin
          state_d  = HOLD;
`ifdef CHARGE_DECAY_EN
          dk_cnt_d = DKW'(DECAY_CYCLES - 1);
`endif
        end else begin
          drv_cnt_d = drv_cnt_q - 1'b1;
        end
      end
      HOLD: begin
`ifdef CHARGE_DECAY_EN
        if (dk_cnt_q == '0) begin
          state_d = IDLE;
          data_d  = '0;
          pulse_d = 1'b1;
        end else begin
          dk_cnt_d = dk_cnt_q - 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // Accept is evaluated last so it beats a coincident decay expiry.
    if (accept) begin
      state_d   = DRIVE;
      drv_cnt_d = DRW'(DRIVE_CYCLES - 1);
      data_d    = in_data;
      pulse_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      drv_cnt_q <= '0;
      data_q    <= '0;
      pulse_q   <= 1'b0;
`ifdef CHARGE_DECAY_EN
      dk_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      drv_cnt_q <= drv_cnt_d;
      data_q    <= data_d;
      pulse_q   <= pulse_d;
`ifdef CHARGE_DECAY_EN
      dk_cnt_q  <= dk_cnt_d;
`endif
    end
  end

  assign drive = (state_q == DRIVE);
  assign known = (state_q != IDLE);
  assign data  = data_q;
  assign pulse = pulse_q;
endmodule

module charge_hold_driver #(
  parameter int WIDTH        = 16,
  parameter int DRIVE_CYCLES = 2,
  parameter int DECAY_CYCLES = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_lane,
  input  logic [WIDTH-1:0]   in_data,
  output logic [2*WIDTH-1:0] bus_data,
  output logic [1:0]         bus_drive,
  output logic [1:0]         bus_known,
  output logic [1:0]         decay_pulse
);
  logic [1:0][WIDTH-1:0] lane_data;
  logic [1:0]            lane_acc;

  assign in_ready = ~bus_drive[in_lane];
  assign bus_data = lane_data;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    assign lane_acc[i] = in_valid && in_ready && (in_lane == 1'(i));
    charge_hold_lane #(
      .WIDTH       (WIDTH),
      .DRIVE_CYCLES(DRIVE_CYCLES),
      .DECAY_CYCLES(DECAY_CYCLES)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .accept (lane_acc[i]),
      .in_data(in_data),
      .drive  (bus_drive[i]),
      .known  (bus_known[i]),
      .data   (lane_data[i]),
      .pulse  (decay_pulse[i])
    );
  end
endmodule

// File: tb/tb_charge_hold_driver.sv
// Bench for charge_hold_driver: vector table plus decay / race / hold sequences.
// Decay-specific sequences run when CHARGE_DECAY_EN is defined; the hold-forever one otherwise.

module tb_charge_hold_driver;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_lane;
  logic [15:0] in_data;
  logic [31:0] bus_data;
  logic [1:0]  bus_drive, bus_known, decay_pulse;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  ed;
    logic [1:0]  ek;
    logic [31:0] eb;
    logic [1:0]  ep;
  } exp_t;

  typedef struct {
    logic        v;
    logic        l;
    logic [15:0] d;
    logic        er;
    logic [1:0]  ed;
    logic [1:0]  ek;
    logic [31:0] eb;
    logic [1:0]  ep;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];

  charge_hold_driver dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane(in_lane), .in_data(in_data), .bus_data(bus_data),
    .bus_drive(bus_drive), .bus_known(bus_known), .decay_pulse(decay_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a sampling point; drives inputs, checks ready, runs one edge.
  task automatic cyc(input logic v, input logic l, input logic [15:0] d, input logic er,
                     input logic [1:0] ed, input logic [1:0] ek, input logic [31:0] eb,
                     input logic [1:0] ep);
    exp_t e;
    in_valid = v; in_lane = l; in_data = d;
    #1;
    if (v) chk("in_ready", {31'b0, in_ready}, {31'b0, er});
    sb.push_back('{ed: ed, ek: ek, eb: eb, ep: ep});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("bus_drive", {30'b0, bus_drive}, {30'b0, e.ed});
    chk("bus_known", {30'b0, bus_known}, {30'b0, e.ek});
    chk("bus_data", bus_data, e.eb);
    chk("decay_pulse", {30'b0, decay_pulse}, {30'b0, e.ep});
  endtask

  task automatic idle(input logic [1:0] ed, input logic [1:0] ek, input logic [31:0] eb,
                      input logic [1:0] ep);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, ed, ek, eb, ep);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_lane = 1'b0; in_data = '0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    //          v  l  data     rdy drive  known  bus             pulse
    vecs[0]  = '{1, 1, 16'h1234, 1, 2'b10, 2'b10, 32'h1234_0000, 2'b00};
    vecs[1]  = '{0, 0, 16'h0000, 0, 2'b10, 2'b10, 32'h1234_0000, 2'b00};
    vecs[2]  = '{0, 0, 16'h0000, 0, 2'b00, 2'b10, 32'h1234_0000, 2'b00};
    vecs[3]  = '{1, 0, 16'hAAAA, 1, 2'b01, 2'b11, 32'h1234_AAAA, 2'b00};
    vecs[4]  = '{1, 0, 16'h5555, 0, 2'b01, 2'b11, 32'h1234_AAAA, 2'b00};
    vecs[5]  = '{1, 0, 16'h5555, 0, 2'b00, 2'b11, 32'h1234_AAAA, 2'b00};
    vecs[6]  = '{1, 0, 16'h5555, 1, 2'b01, 2'b11, 32'h1234_5555, 2'b00};
    vecs[7]  = '{1, 1, 16'h0F0F, 1, 2'b11, 2'b11, 32'h0F0F_5555, 2'b00};
    vecs[8]  = '{0, 0, 16'h0000, 0, 2'b10, 2'b11, 32'h0F0F_5555, 2'b00};
    vecs[9]  = '{0, 0, 16'h0000, 0, 2'b00, 2'b11, 32'h0F0F_5555, 2'b00};
    vecs[10] = '{1, 0, 16'hA5A5, 1, 2'b01, 2'b11, 32'h0F0F_A5A5, 2'b00};

    rst = 1'b1; in_valid = 1'b0; in_lane = 1'b0; in_data = '0;
    #2;
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_drive", {30'b0, bus_drive}, 32'd0);
    chk("rst_known", {30'b0, bus_known}, 32'd0);
    chk("rst_data", bus_data, 32'd0);
    chk("rst_pulse", {30'b0, decay_pulse}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      cyc(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].er, vecs[i].ed, vecs[i].ek, vecs[i].eb, vecs[i].ep);

    // Asynchronous reset mid-DRIVE of lane 0 holding A5A5.
    in_valid = 1'b0; in_lane = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_drive", {30'b0, bus_drive}, 32'd0);
    chk("arst_known", {30'b0, bus_known}, 32'd0);
    chk("arst_data", bus_data, 32'd0);
    chk("arst_pulse", {30'b0, decay_pulse}, 32'd0);
    chk("arst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("post_rst_drive", {30'b0, bus_drive}, 32'd0);

`ifdef CHARGE_DECAY_EN
    // Single word on lane 1: 2 drive, 50 hold, 1 pulse cycle.
    do_reset();
    cyc(1'b1, 1'b1, 16'h1234, 1'b1, 2'b10, 2'b10, 32'h1234_0000, 2'b00);
    idle(2'b10, 2'b10, 32'h1234_0000, 2'b00);
    for (int i = 0; i < 50; i++) idle(2'b00, 2'b10, 32'h1234_0000, 2'b00);
    idle(2'b00, 2'b00, 32'h0, 2'b10);
    idle(2'b00, 2'b00, 32'h0, 2'b00);

    // Accept exactly at the HOLD expiry edge wins over decay.
    do_reset();
    cyc(1'b1, 1'b0, 16'h1111, 1'b1, 2'b01, 2'b01, 32'h0000_1111, 2'b00);
    idle(2'b01, 2'b01, 32'h0000_1111, 2'b00);
    for (int i = 0; i < 50; i++) idle(2'b00, 2'b01, 32'h0000_1111, 2'b00);
    cyc(1'b1, 1'b0, 16'hBEEF, 1'b1, 2'b01, 2'b01, 32'h0000_BEEF, 2'b00);
    idle(2'b01, 2'b01, 32'h0000_BEEF, 2'b00);

    // Lane 0 accepts on the same edge lane 1 decays.
    do_reset();
    cyc(1'b1, 1'b1, 16'h2222, 1'b1, 2'b10, 2'b10, 32'h2222_0000, 2'b00);
    idle(2'b10, 2'b10, 32'h2222_0000, 2'b00);
    for (int i = 0; i < 50; i++) idle(2'b00, 2'b10, 32'h2222_0000, 2'b00);
    cyc(1'b1, 1'b0, 16'h7777, 1'b1, 2'b01, 2'b01, 32'h0000_7777, 2'b10);
`else
    // Without decay, a released lane holds its charge indefinitely.
    do_reset();
    cyc(1'b1, 1'b0, 16'h00FF, 1'b1, 2'b01, 2'b01, 32'h0000_00FF, 2'b00);
    idle(2'b01, 2'b01, 32'h0000_00FF, 2'b00);
    for (int i = 0; i < 200; i++) idle(2'b00, 2'b01, 32'h0000_00FF, 2'b00);
    cyc(1'b1, 1'b0, 16'h0123, 1'b1, 2'b01, 2'b01, 32'h0000_0123, 2'b00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
